// File: rtl/xrv1_mem_arb_pkg.sv
// Shared types and constants for the XRV1 memory arbiter.
// The owner id travels through the in-order response queue.
package xrv1_mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    OWNER_IMEM = 1'b0,
    OWNER_DMEM = 1'b1
  } owner_e;

endpackage

// File: rtl/xrv1_owner_fifo.sv
// In-order queue of request owners; the head steers each returning response.
// Wrap-around pointers plus an occupancy count give exact full/empty.
module xrv1_owner_fifo
  import xrv1_mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  owner_e push_id_i,
  input  logic   pop_i,
  output owner_e head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  owner_e           slot_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

  assign full_o  = (count_r == FULL_CNT);
  assign empty_o = (count_r == {CNT_W{1'b0}});
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = slot_r[rd_ptr_r];

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) slot_r[i] <= OWNER_IMEM;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        slot_r[wr_ptr_r] <= push_id_i;
        wr_ptr_r         <= next_ptr(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/xrv1_mem_arb.sv
// Shares one memory port between the XRV1 fetch and data ports with zero added
// latency: dmem priority with bounded fetch starvation, stall lock, in-order routing.
module xrv1_mem_arb
  import xrv1_mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  imem_req_vld_i,
  output logic                  imem_req_rdy_o,
  input  logic [MEM_ADDR_W-1:0] imem_req_addr_i,
  output logic                  imem_resp_vld_o,
  output logic [MEM_DATA_W-1:0] imem_resp_data_o,
  input  logic                  dmem_req_vld_i,
  output logic                  dmem_req_rdy_o,
  input  logic [MEM_ADDR_W-1:0] dmem_req_addr_i,
  input  logic                  dmem_req_w_en_i,
  input  logic [3:0]            dmem_req_w_be_i,
  input  logic [MEM_DATA_W-1:0] dmem_req_w_data_i,
  output logic                  dmem_resp_vld_o,
  output logic [MEM_DATA_W-1:0] dmem_resp_r_data_o,
  output logic                  dmem_resp_err_o,
  output logic                  mem_req_vld_o,
  input  logic                  mem_req_rdy_i,
  output logic [MEM_ADDR_W-1:0] mem_req_addr_o,
  output logic                  mem_req_w_en_o,
  output logic [3:0]            mem_req_w_be_o,
  output logic [MEM_DATA_W-1:0] mem_req_w_data_o,
  input  logic                  mem_resp_vld_i,
  input  logic [MEM_DATA_W-1:0] mem_resp_r_data_i,
  input  logic                  mem_resp_err_i,
  output logic                  spurious_resp_o
);

  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                lock_r;
  owner_e              lock_src_r;
  logic [STARVE_W-1:0] starve_cnt_r;
  logic                spurious_r;
  owner_e              grant_s;
  logic                grant_vld_s;
  logic                starved_s;
  logic                accept_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  owner_e              head_s;
  logic                resp_hit_s;

  // With STARVE_LIMIT=0 imem never gets the priority grant
  assign starved_s = (STARVE_LIMIT != 0) && (starve_cnt_r == STARVE_MAX);

  // Grant selection: a stalled request keeps its source until accepted
  always_comb begin
    grant_s = OWNER_IMEM;
    if (lock_r) begin
      grant_s = lock_src_r;
    end else if (imem_req_vld_i && dmem_req_vld_i) begin
      grant_s = starved_s ? OWNER_IMEM : OWNER_DMEM;
    end else if (dmem_req_vld_i) begin
      grant_s = OWNER_DMEM;
    end else begin
      grant_s = OWNER_IMEM;
    end
  end

  // Request field mux; a fetch never writes
  always_comb begin
    grant_vld_s      = 1'b0;
    mem_req_addr_o   = imem_req_addr_i;
    mem_req_w_en_o   = 1'b0;
    mem_req_w_be_o   = 4'b0000;
    mem_req_w_data_o = {MEM_DATA_W{1'b0}};
    case (grant_s)
      OWNER_DMEM: begin
        grant_vld_s      = dmem_req_vld_i;
        mem_req_addr_o   = dmem_req_addr_i;
        mem_req_w_en_o   = dmem_req_w_en_i;
        mem_req_w_be_o   = dmem_req_w_be_i;
        mem_req_w_data_o = dmem_req_w_data_i;
      end
      OWNER_IMEM: grant_vld_s = imem_req_vld_i;
      default:    grant_vld_s = 1'b0;
    endcase
  end

  // Full blocks issue even when a pop coincides, keeping mem_resp_vld_i off this path
  assign mem_req_vld_o  = grant_vld_s & ~fifo_full_s;
  assign accept_s       = mem_req_vld_o & mem_req_rdy_i;
  assign imem_req_rdy_o = accept_s & (grant_s == OWNER_IMEM);
  assign dmem_req_rdy_o = accept_s & (grant_s == OWNER_DMEM);

  xrv1_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (accept_s),
    .push_id_i (grant_s),
    .pop_i     (mem_resp_vld_i),
    .head_o    (head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  assign resp_hit_s         = mem_resp_vld_i & ~fifo_empty_s;
  assign imem_resp_vld_o    = resp_hit_s & (head_s == OWNER_IMEM);
  assign dmem_resp_vld_o    = resp_hit_s & (head_s == OWNER_DMEM);
  assign imem_resp_data_o   = mem_resp_r_data_i;
  assign dmem_resp_r_data_o = mem_resp_r_data_i;
  assign dmem_resp_err_o    = mem_resp_err_i;
  assign spurious_resp_o    = spurious_r;

  // Lock, starvation counter and sticky spurious-response flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_r       <= 1'b0;
      lock_src_r   <= OWNER_IMEM;
      starve_cnt_r <= {STARVE_W{1'b0}};
      spurious_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        lock_r <= 1'b0;
      end else if (mem_req_vld_o) begin
        lock_r     <= 1'b1;
        lock_src_r <= grant_s;
      end
      if (accept_s && grant_s == OWNER_IMEM) begin
        starve_cnt_r <= {STARVE_W{1'b0}};
      end else if (accept_s && imem_req_vld_i && starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + {{(STARVE_W-1){1'b0}}, 1'b1};
      end
      if (mem_resp_vld_i && fifo_empty_s) spurious_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xrv1_mem_arb.sv
// Randomized bench for xrv1_mem_arb against a transaction-level reference model,
// followed by directed grant-order, lock, full-queue, spurious and reset scenarios.
module tb_xrv1_mem_arb;
  import xrv1_mem_arb_pkg::*;

  localparam int MAX_OUT = 2;
  localparam int LIMIT   = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_vld_i, imem_req_rdy_o, imem_resp_vld_o;
  logic [31:0] imem_req_addr_i, imem_resp_data_o;
  logic        dmem_req_vld_i, dmem_req_rdy_o, dmem_req_w_en_i;
  logic [31:0] dmem_req_addr_i, dmem_req_w_data_i, dmem_resp_r_data_o;
  logic [3:0]  dmem_req_w_be_i;
  logic        dmem_resp_vld_o, dmem_resp_err_o;
  logic        mem_req_vld_o, mem_req_rdy_i, mem_req_w_en_o;
  logic [31:0] mem_req_addr_o, mem_req_w_data_o;
  logic [3:0]  mem_req_w_be_o;
  logic        mem_resp_vld_i, mem_resp_err_i, spurious_resp_o;
  logic [31:0] mem_resp_r_data_i;

  xrv1_mem_arb #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_vld_i(imem_req_vld_i), .imem_req_rdy_o(imem_req_rdy_o),
    .imem_req_addr_i(imem_req_addr_i), .imem_resp_vld_o(imem_resp_vld_o),
    .imem_resp_data_o(imem_resp_data_o),
    .dmem_req_vld_i(dmem_req_vld_i), .dmem_req_rdy_o(dmem_req_rdy_o),
    .dmem_req_addr_i(dmem_req_addr_i), .dmem_req_w_en_i(dmem_req_w_en_i),
    .dmem_req_w_be_i(dmem_req_w_be_i), .dmem_req_w_data_i(dmem_req_w_data_i),
    .dmem_resp_vld_o(dmem_resp_vld_o), .dmem_resp_r_data_o(dmem_resp_r_data_o),
    .dmem_resp_err_o(dmem_resp_err_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_w_en_o(mem_req_w_en_o),
    .mem_req_w_be_o(mem_req_w_be_o), .mem_req_w_data_o(mem_req_w_data_o),
    .mem_resp_vld_i(mem_resp_vld_i), .mem_resp_r_data_i(mem_resp_r_data_i),
    .mem_resp_err_i(mem_resp_err_i), .spurious_resp_o(spurious_resp_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who is owed a response, in order, and what data it must see
  bit          m_owner_q[$];
  logic [31:0] mq_data[$];
  bit          mq_err[$];
  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  bit          d_err_exp[$];
  int          m_starve;
  bit          m_pend_valid, m_pend_dmem;
  bit          drop_i, drop_d;
  bit          last_acc_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner_q.delete(); mq_data.delete(); mq_err.delete();
    i_exp.delete(); d_exp.delete(); d_err_exp.delete();
    m_starve = 0; m_pend_valid = 0; m_pend_dmem = 0; drop_i = 0; drop_d = 0;
  endtask

  task automatic clear_inputs();
    imem_req_vld_i = 0; imem_req_addr_i = 0;
    dmem_req_vld_i = 0; dmem_req_addr_i = 0; dmem_req_w_en_i = 0;
    dmem_req_w_be_i = 0; dmem_req_w_data_i = 0;
    mem_req_rdy_i = 0; mem_resp_vld_i = 0; mem_resp_r_data_i = 0; mem_resp_err_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0;
    clear_inputs();
    #1;
    check_eq("rst_mem_vld", mem_req_vld_o, 0);
    check_eq("rst_rdy", {imem_req_rdy_o, dmem_req_rdy_o}, 0);
    check_eq("rst_resp_vld", {imem_resp_vld_o, dmem_resp_vld_o}, 0);
    check_eq("rst_spurious", spurious_resp_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();
  endtask

  // One cycle of randomized traffic, checked against the model before the edge
  task automatic run_cycle(input int p_req, input int p_rdy, input int p_resp);
    bit g_d, gv, full, ev, acc, has_head, head_d;
    @(negedge clk_i);
    if (drop_i) imem_req_vld_i = 0;
    if (drop_d) dmem_req_vld_i = 0;
    drop_i = 0; drop_d = 0;
    if (!imem_req_vld_i && $urandom_range(99) < p_req) begin
      imem_req_vld_i = 1; imem_req_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (!dmem_req_vld_i && $urandom_range(99) < p_req) begin
      dmem_req_vld_i = 1; dmem_req_addr_i = $urandom;
      dmem_req_w_en_i = 1'($urandom); dmem_req_w_be_i = 4'($urandom);
      dmem_req_w_data_i = $urandom;
    end
    mem_req_rdy_i = ($urandom_range(99) < p_rdy);
    if (mq_data.size() > 0 && $urandom_range(99) < p_resp) begin
      mem_resp_vld_i = 1; mem_resp_r_data_i = mq_data[0]; mem_resp_err_i = mq_err[0];
    end else begin
      mem_resp_vld_i = 0; mem_resp_r_data_i = $urandom; mem_resp_err_i = 1'($urandom);
    end
    #1;
    if (m_pend_valid) g_d = m_pend_dmem;
    else if (imem_req_vld_i && dmem_req_vld_i) g_d = !(LIMIT > 0 && m_starve >= LIMIT);
    else g_d = dmem_req_vld_i;
    gv   = g_d ? dmem_req_vld_i : imem_req_vld_i;
    full = (m_owner_q.size() >= MAX_OUT);
    ev   = gv && !full;
    acc  = ev && mem_req_rdy_i;
    check_eq("mem_req_vld", mem_req_vld_o, ev);
    check_eq("imem_rdy", imem_req_rdy_o, acc && !g_d);
    check_eq("dmem_rdy", dmem_req_rdy_o, acc && g_d);
    if (ev) begin
      check_eq("req_addr", mem_req_addr_o, g_d ? dmem_req_addr_i : imem_req_addr_i);
      check_eq("req_w_en", mem_req_w_en_o, g_d ? dmem_req_w_en_i : 1'b0);
      check_eq("req_w_be", mem_req_w_be_o, g_d ? dmem_req_w_be_i : 4'b0000);
      check_eq("req_w_data", mem_req_w_data_o, g_d ? dmem_req_w_data_i : 32'h0);
    end
    has_head = mem_resp_vld_i && m_owner_q.size() > 0;
    head_d   = has_head ? m_owner_q[0] : 1'b0;
    check_eq("imem_resp_vld", imem_resp_vld_o, has_head && !head_d);
    check_eq("dmem_resp_vld", dmem_resp_vld_o, has_head && head_d);
    if (imem_resp_vld_o) begin
      if (i_exp.size() == 0) check_eq("imem_resp_unexpected", 1, 0);
      else check_eq("imem_resp_data", imem_resp_data_o, i_exp.pop_front());
    end
    if (dmem_resp_vld_o) begin
      if (d_exp.size() == 0) check_eq("dmem_resp_unexpected", 1, 0);
      else begin
        check_eq("dmem_resp_data", dmem_resp_r_data_o, d_exp.pop_front());
        check_eq("dmem_resp_err", dmem_resp_err_o, d_err_exp.pop_front());
      end
    end
    check_eq("spurious_idle", spurious_resp_o, 0);
    if (has_head) begin
      void'(m_owner_q.pop_front()); void'(mq_data.pop_front()); void'(mq_err.pop_front());
    end
    last_acc_i = acc && !g_d;
    if (acc) begin
      logic [31:0] rd;
      bit er;
      rd = $urandom;
      er = g_d ? 1'($urandom) : 1'b0;
      m_owner_q.push_back(g_d); mq_data.push_back(rd); mq_err.push_back(er);
      if (g_d) begin
        d_exp.push_back(rd); d_err_exp.push_back(er); drop_d = 1;
        if (imem_req_vld_i) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      end else begin
        i_exp.push_back(rd); drop_i = 1; m_starve = 0;
      end
      m_pend_valid = 0;
    end else if (ev) begin
      m_pend_valid = 1; m_pend_dmem = g_d;
    end
  endtask

  initial begin
    logic [9:0] seq;
    clear_inputs();
    model_reset();
    do_reset();

    for (int i = 0; i < 3000; i++) run_cycle(60, 70, 50);

    // Saturated traffic: D,D,D,D,I repeating
    do_reset();
    seq = 10'h000;
    for (int i = 0; i < 10; i++) begin
      run_cycle(100, 100, 100);
      seq[i] = last_acc_i;
    end
    check_eq("grant_order", seq, 10'h210);

    // Stalled dmem grant stays put while imem joins
    do_reset();
    @(negedge clk_i);
    dmem_req_vld_i = 1; dmem_req_addr_i = 32'h0000_0100; mem_req_rdy_i = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin imem_req_vld_i = 1; imem_req_addr_i = 32'h0000_0200; end
      #1;
      check_eq("lock_vld", mem_req_vld_o, 1);
      check_eq("lock_addr", mem_req_addr_o, 32'h0000_0100);
      check_eq("lock_imem_rdy", imem_req_rdy_o, 0);
      @(negedge clk_i);
    end
    mem_req_rdy_i = 1;
    #1;
    check_eq("lock_accept_d", dmem_req_rdy_o, 1);
    check_eq("lock_accept_i", imem_req_rdy_o, 0);
    check_eq("lock_accept_addr", mem_req_addr_o, 32'h0000_0100);
    @(negedge clk_i);
    dmem_req_vld_i = 0;
    #1;
    check_eq("lock_then_imem", imem_req_rdy_o, 1);

    // Spurious response on an empty queue is dropped and latched
    do_reset();
    @(negedge clk_i);
    mem_resp_vld_i = 1; mem_resp_r_data_i = 32'hDEAD_BEEF;
    #1;
    check_eq("spur_resp_vld", {imem_resp_vld_o, dmem_resp_vld_o}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      mem_resp_vld_i = 0;
      #1;
      check_eq("spur_sticky", spurious_resp_o, 1);
    end

    // Queue fills after MAX_OUT acceptances; a response reopens issue a cycle later
    do_reset();
    @(negedge clk_i);
    imem_req_vld_i = 1; imem_req_addr_i = 32'h0000_0040; mem_req_rdy_i = 1;
    #1; check_eq("full_acc1", imem_req_rdy_o, 1);
    @(negedge clk_i); #1; check_eq("full_acc2", imem_req_rdy_o, 1);
    @(negedge clk_i); #1; check_eq("full_block", {mem_req_vld_o, imem_req_rdy_o}, 0);
    @(negedge clk_i);
    mem_resp_vld_i = 1; mem_resp_r_data_i = 32'h0000_000A;
    #1;
    check_eq("full_pop_block", mem_req_vld_o, 0);
    check_eq("full_pop_resp", imem_resp_vld_o, 1);
    @(negedge clk_i);
    mem_resp_vld_i = 0;
    #1; check_eq("full_reissue", mem_req_vld_o, 1);
    @(negedge clk_i); #1; check_eq("full_again", mem_req_vld_o, 0);

    // Asynchronous reset with two outstanding requests
    #2;
    rst_ni = 0;
    #1;
    check_eq("arst_queue_empty", mem_req_vld_o, 1);
    check_eq("arst_spurious", spurious_resp_o, 0);
    imem_req_vld_i = 0; mem_req_rdy_i = 0;
    #1;
    check_eq("arst_outputs", {mem_req_vld_o, imem_req_rdy_o, dmem_req_rdy_o,
                              imem_resp_vld_o, dmem_resp_vld_o}, 0);
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    mem_resp_vld_i = 1;
    #1;
    check_eq("post_rst_resp_vld", {imem_resp_vld_o, dmem_resp_vld_o}, 0);
    @(negedge clk_i);
    mem_resp_vld_i = 0;
    #1;
    check_eq("post_rst_spurious", spurious_resp_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
